buffer: RTL and testbench

Non-inverting buffer cell for the Hack FPGA datapath. It drives `out` combinationally from `in` with zero clock latency, so it is legal on any combinational path. Alongside the buffer it provides clocked observation logic: a registered copy of the input, per-bit edge strobes and an optional saturating toggle counter. The observation logic is used for signal monitoring and debug taps.

---
 rtl/hack_pkg.sv | 15 +
 rtl/buffer_edge_det.sv | 26 ++
 rtl/buffer.sv | 56 +++++
 tb/tb_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack FPGA datapath cells.
// Holds the buffer defaults and the per-bit edge strobe record.
`timescale 1ns/1ps
package hack_pkg;

    localparam int WIDTH_DEFAULT = 1;
    localparam int CNT_W_DEFAULT = 16;

    // One bit's worth of edge strobes, produced together on the same clock.
    typedef struct packed {
        logic rise;
        logic fall;
    } buffer_edge_t;

endpackage

// File: rtl/buffer_edge_det.sv
// Single-bit sampler with registered rise/fall strobes.
// The held sample doubles as the "previous value" the strobes compare against.
`timescale 1ns/1ps
module buffer_edge_det
    import hack_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         d,
    output logic         q,
    output buffer_edge_t strobe
);

    // Sample d every edge and flag a 0->1 or 1->0 change against the old sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= 1'b0;
            strobe <= '0;
        end else begin
            q           <= d;
            strobe.rise <= d & ~q;
            strobe.fall <= ~d & q;
        end
    end

endmodule

// File: rtl/buffer.sv
// Non-inverting buffer with clocked observation taps (registered copy, edge strobes).
// Define BUFFER_TOGGLE_CNT_EN to add the saturating toggle counter and its clear input.
`timescale 1ns/1ps
module buffer
    import hack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`ifdef BUFFER_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt,
    input  logic             cnt_clr
`endif
);

    buffer_edge_t strobe [WIDTH];

    // The buffer path itself: no clock or reset involvement, X/Z pass straight through.
    assign out = in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        buffer_edge_det u_edge_det (
            .clk    (clk),
            .rst_n  (rst_n),
            .d      (in[i]),
            .q      (out_q[i]),
            .strobe (strobe[i])
        );
        assign rise[i] = strobe[i].rise;
        assign fall[i] = strobe[i].fall;
    end

`ifdef BUFFER_TOGGLE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count sampled cycles with any bit changing; clear wins, and the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_cnt <= '0;
        end else if (cnt_clr) begin
            toggle_cnt <= '0;
        end else if ((in != out_q) && (toggle_cnt != CNT_MAX)) begin
            toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_buffer.sv
// Testbench for buffer: directed combinational/reset checks plus a randomized
// scoreboard run. Counter checks are active when BUFFER_TOGGLE_CNT_EN is defined.
`timescale 1ns/1ps
module tb_buffer;

    localparam int CW = 2;

    typedef struct {
        logic [7:0]    q;
        logic [7:0]    r;
        logic [7:0]    f;
        logic [CW-1:0] c;
    } exp_t;

    logic          clk;
    logic          clk_run;
    logic          rst_n;
    logic [0:0]    in1;
    logic [0:0]    out1;
    logic [0:0]    out_q1;
    logic [0:0]    rise1;
    logic [0:0]    fall1;
    logic [7:0]    in8;
    logic [7:0]    out8;
    logic [7:0]    out_q8;
    logic [7:0]    rise8;
    logic [7:0]    fall8;
    logic          cnt_clr;
    logic [CW-1:0] cnt8;
    logic [15:0]   cnt1;

    exp_t       exp_q [$];
    int         checks;
    int         errors;

    // reference model state: last value sampled while out of reset, and toggle count
    logic [7:0] m_prev;
    int         m_cnt;

`ifdef BUFFER_TOGGLE_CNT_EN
    buffer #(.WIDTH(8), .CNT_W(CW)) dut8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .out(out8), .out_q(out_q8),
        .rise(rise8), .fall(fall8), .toggle_cnt(cnt8), .cnt_clr(cnt_clr)
    );
    buffer #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .out(out1), .out_q(out_q1),
        .rise(rise1), .fall(fall1), .toggle_cnt(cnt1), .cnt_clr(cnt_clr)
    );
`else
    buffer #(.WIDTH(8), .CNT_W(CW)) dut8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .out(out8), .out_q(out_q8),
        .rise(rise8), .fall(fall8)
    );
    buffer #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .out(out1), .out_q(out_q1),
        .rise(rise1), .fall(fall1)
    );
    assign cnt8 = '0;
    assign cnt1 = '0;
`endif

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of input at the falling edge and queue what the next rising edge must show.
    task automatic applyStimulus(input logic [7:0] v, input logic clr, input logic rstn);
        exp_t e;
        @(negedge clk);
        in8     = v;
        cnt_clr = clr;
        rst_n   = rstn;
        if (!rstn) begin
            e.q = 8'h00; e.r = 8'h00; e.f = 8'h00;
            m_prev = 8'h00;
            m_cnt  = 0;
        end else begin
            e.r = v & ~m_prev;
            e.f = ~v & m_prev;
            e.q = v;
            if (clr)
                m_cnt = 0;
            else if (v != m_prev && m_cnt < (1 << CW) - 1)
                m_cnt = m_cnt + 1;
            m_prev = v;
        end
        e.c = CW'(m_cnt);
        exp_q.push_back(e);
        #1;
        checkOutput("out_comb", {24'h0, out8}, {24'h0, v});
    endtask

    // Monitor: after every rising edge, compare the registered outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("out_q", {24'h0, out_q8}, {24'h0, e.q});
                checkOutput("rise",  {24'h0, rise8},  {24'h0, e.r});
                checkOutput("fall",  {24'h0, fall8},  {24'h0, e.f});
`ifdef BUFFER_TOGGLE_CNT_EN
                checkOutput("toggle_cnt", {30'h0, cnt8}, {30'h0, e.c});
`endif
            end
        end
    end

    initial begin
        logic [7:0] v;
        checks  = 0;
        errors  = 0;
        clk_run = 1'b0;
        m_prev  = 8'h00;
        m_cnt   = 0;
        cnt_clr = 1'b0;
        in1     = 1'b0;
        in8     = 8'h00;
        rst_n   = 1'b1;
        #1;
        rst_n   = 1'b0;

        // no clock running: buffer path and reset state
        #1;
        checkOutput("w1_out_0", {31'h0, out1}, 32'h0);
        in1 = 1'b1;
        #1;
        checkOutput("w1_out_1", {31'h0, out1}, 32'h1);
        checkOutput("w1_outq_rst", {31'h0, out_q1}, 32'h0);
        in8 = 8'hA5;
        #1;
        checkOutput("w8_out_A5", {24'h0, out8}, 32'hA5);
        in8 = 8'h5A;
        #1;
        checkOutput("w8_out_5A", {24'h0, out8}, 32'h5A);
        checkOutput("w8_outq_rst", {24'h0, out_q8}, 32'h0);
        checkOutput("w8_rise_rst", {24'h0, rise8}, 32'h0);
        checkOutput("cnt_rst", {30'h0, cnt8}, 32'h0);

        clk_run = 1'b1;

        // reset held while input toggles: only the combinational path moves
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 1'b0, 1'b0);

        // release, then 0->1->1->0 on bit 0
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'h01, 1'b0, 1'b1);
        applyStimulus(8'h01, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1);

        // wide patterns with registered follow-up
        applyStimulus(8'hA5, 1'b0, 1'b1);
        applyStimulus(8'h5A, 1'b0, 1'b1);
        applyStimulus(8'h5A, 1'b0, 1'b1);

        // counter: clear, five toggles to saturation, then clear together with a change
        applyStimulus(8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus((i % 2 == 0) ? 8'hFF : 8'h00, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b1, 1'b1);
        applyStimulus(8'h0F, 1'b1, 1'b1);

        // reset dropped between edges while a rise strobe is showing
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'h01, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        checkOutput("rise_before_rst", {24'h0, rise8}, 32'h01);
        rst_n  = 1'b0;
        m_prev = 8'h00;
        m_cnt  = 0;
        #1;
        checkOutput("rise_async_rst", {24'h0, rise8}, 32'h0);
        checkOutput("outq_async_rst", {24'h0, out_q8}, 32'h0);
        checkOutput("cnt_async_rst", {30'h0, cnt8}, 32'h0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b1);

        // randomized traffic with occasional clears and resets
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) == 0) ? m_prev : 8'($urandom);
            applyStimulus(v, ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) != 0));
        end

        @(posedge clk);
        #2;
        checkOutput("queue_drained", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
